// File: rtl/mix_engine.sv
// mix_engine: multi-round lane mixer with valid/ready job handshake and completed-job counter
module mix_engine #(
    parameter int WIDTH = 32,
    parameter int LANES = 8,
    parameter int RW    = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*WIDTH-1:0] in_data,
    input  logic [RW-1:0]          in_rounds,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*WIDTH-1:0] out_data,
    output logic                   busy,
    output logic [15:0]            job_count
);
    typedef enum logic [1:0] {IDLE, MIX, DONE} state_t;
    state_t state, state_nx;
    logic [WIDTH-1:0] s [LANES];
    logic [WIDTH-1:0] mixed [LANES];
    logic [RW-1:0] r, rounds;
    logic accept, take;

    assign accept = in_valid && in_ready;
    assign take   = out_valid && out_ready;

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= state_nx;
    end

    // next-state: zero-round jobs skip MIX; the last round is the one where r hits R-1
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = in_valid ? ((in_rounds != '0) ? MIX : DONE) : IDLE;
            MIX:     state_nx = (r == rounds - RW'(1)) ? DONE : MIX;
            DONE:    state_nx = out_ready ? IDLE : DONE;
            default: state_nx = IDLE;
        endcase
    end

    // handshake and status outputs decoded from state
    always_comb begin
        in_ready  = (state == IDLE);
        busy      = (state == MIX);
        out_valid = (state == DONE);
    end

    // one mix round, every lane computed from the pre-round values
    always_comb begin
        for (int i = 0; i < LANES; i++)
            mixed[i] = ((s[i] + s[(i + 1) % LANES]) ^ (s[(i + LANES - 1) % LANES] << (WIDTH / 2))) + WIDTH'(r);
    end

    // lane, round-index and round-count registers; inputs are only sampled on accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s      <= '{default: '0};
            r      <= '0;
            rounds <= '0;
        end else if (accept) begin
            for (int i = 0; i < LANES; i++) s[i] <= in_data[i*WIDTH +: WIDTH];
            rounds <= in_rounds;
            r      <= '0;
        end else if (state == MIX) begin
            s <= mixed;
            r <= r + RW'(1);
        end
    end

    // completed-job counter, wraps naturally at 16 bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) job_count <= '0;
        else if (take) job_count <= job_count + 16'd1;
    end

    // lanes packed back onto the output bus
    always_comb begin
        out_data = '0;
        for (int i = 0; i < LANES; i++) out_data[i*WIDTH +: WIDTH] = s[i];
    end
endmodule

// File: tb/tb_mix_engine.sv
// tb_mix_engine: directed self-checking bench for mix_engine (WIDTH=32, LANES=8, RW=4)
module tb_mix_engine;
    logic         clk = 0;
    logic         rst_n = 0;
    logic         in_valid = 0;
    logic         in_ready;
    logic [255:0] in_data = '0;
    logic [3:0]   in_rounds = '0;
    logic         out_valid;
    logic         out_ready = 0;
    logic [255:0] out_data;
    logic         busy;
    logic [15:0]  job_count;
    int errors = 0;
    int checks = 0;

    mix_engine dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_rounds(in_rounds), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .busy(busy), .job_count(job_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input string tag, input logic [255:0] d, input logic [3:0] rr);
        in_data = d;
        in_rounds = rr;
        in_valid = 1;
        check({tag, "_in_ready"}, in_ready, 1);
        tick;
        in_valid = 0;
    endtask

    task automatic wait_done(input string tag, input int rr);
        int n = 1;
        int b = 0;
        b += busy;
        while (!out_valid && n < 40) begin
            tick;
            n++;
            b += busy;
        end
        check({tag, "_latency"}, n, rr + 1);
        check({tag, "_busy_cycles"}, b, rr);
    endtask

    task automatic take(input string tag);
        out_ready = 1;
        tick;
        out_ready = 0;
        check({tag, "_out_valid_after_take"}, out_valid, 0);
        check({tag, "_in_ready_after_take"}, in_ready, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [255:0] li, ones, snap;
        int ok;
        for (int i = 0; i < 8; i++) li[i*32 +: 32] = 32'(i);
        ones = '1;

        tick;
        tick;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_out_data", out_data, 0);
        check("rst_job_count", job_count, 0);

        @(negedge clk) rst_n = 1;
        start_job("abort", li, 4'd10);
        check("first_accept_busy", busy, 1);
        tick;
        tick;
        tick;
        @(negedge clk) rst_n = 0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_in_ready", in_ready, 1);
        check("abort_out_valid", out_valid, 0);
        check("abort_out_data", out_data, 0);
        check("abort_job_count", job_count, 0);
        @(negedge clk) rst_n = 1;

        start_job("r1", li, 4'd1);
        wait_done("r1", 1);
        check("r1_lane0", out_data[0*32 +: 32], 32'h0007_0001);
        check("r1_lane1", out_data[1*32 +: 32], 32'h0000_0003);
        check("r1_lane2", out_data[2*32 +: 32], 32'h0001_0005);
        check("r1_lane7", out_data[7*32 +: 32], 32'h0006_0007);
        take("r1");
        check("r1_job_count", job_count, 1);

        start_job("r0", li, 4'd0);
        wait_done("r0", 0);
        check("r0_passthrough", out_data, li);
        take("r0");
        check("r0_job_count", job_count, 2);

        start_job("r15", li, 4'd15);
        in_valid = 1;
        in_data = ones;
        in_rounds = 4'd0;
        wait_done("r15", 15);
        snap = out_data;
        ok = 1;
        for (int i = 0; i < 20; i++) begin
            in_valid = i[0];
            in_data = {8{$urandom}};
            tick;
            if (out_data !== snap || !out_valid || in_ready || busy) ok = 0;
        end
        check("r15_stall_stable", ok, 1);
        in_valid = 1;
        take("r15");
        in_valid = 0;
        check("r15_job_count", job_count, 3);

        start_job("ones", ones, 4'd2);
        in_data = '0;
        in_rounds = 4'd5;
        in_valid = 1;
        wait_done("ones", 2);
        in_valid = 0;
        check("ones_result", out_data, {8{32'hFFFF_FFFD}});
        take("ones");
        check("ones_job_count", job_count, 4);

        force dut.job_count = 16'hFFFF;
        #1;
        release dut.job_count;
        #1;
        check("preload_job_count", job_count, 16'hFFFF);
        start_job("wrap", li, 4'd0);
        wait_done("wrap", 0);
        take("wrap");
        check("wrap_job_count", job_count, 16'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
